// File: rtl/adsr_pkg.sv
// Shared types and helpers for the polyphonic ADSR envelope generator.
// State encoding, rate-code increment and sustain-level expansion.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int MAX_WIDTH = 24;

  // Code 0 steps by half of full scale; larger codes halve the step down to 1.
  function automatic logic [31:0] rate_inc(input logic [3:0] code, input int width);
    if (int'(code) <= width - 1) begin
      return 32'd1 << (width - 1 - int'(code));
    end
    return 32'd1;
  endfunction

  function automatic logic [31:0] sustain_level(input logic [3:0] s, input int width);
    logic [31:0] rep;
    rep = {8{s}};
    return rep >> (32 - width);
  endfunction

endpackage

// File: rtl/adsr_if.sv
// Control and level bus between the key/gate logic, the envelope sequencer and the VCAs.
// Pure wiring; no timing of its own.
interface adsr_if #(
  parameter int VOICES = 4,
  parameter int WIDTH  = 16
);
  logic                      low_clk;
  logic [VOICES-1:0]         gate;
  logic [VOICES-1:0]         retrig;
  logic [4*VOICES-1:0]       a;
  logic [4*VOICES-1:0]       d;
  logic [4*VOICES-1:0]       s;
  logic [4*VOICES-1:0]       r;
  logic [WIDTH*VOICES-1:0]   signal_out;
  logic [VOICES-1:0]         active;
  logic                      busy;
  logic                      overrun;

  modport master (
    output low_clk, gate, retrig, a, d, s, r,
    input  signal_out, active, busy, overrun
  );

  modport slave (
    input  low_clk, gate, retrig, a, d, s, r,
    output signal_out, active, busy, overrun
  );
endinterface

// File: rtl/adsr_voice_step.sv
// One envelope step for one voice: current state/level plus controls -> next state/level.
// Purely combinational, zero latency; no handshake.
module adsr_voice_step
  import adsr_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int RESTART_ZERO = 0
) (
  input  state_t            state_i,
  input  logic [WIDTH-1:0]  level_i,
  input  logic              gate_i,
  input  logic              pending_i,
  input  logic [3:0]        a_i,
  input  logic [3:0]        d_i,
  input  logic [3:0]        s_i,
  input  logic [3:0]        r_i,
  output state_t            next_state_o,
  output logic [WIDTH-1:0]  next_level_o
);

  localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] lvl, inc_a, inc_d, inc_r, sl, sum_a, dec_d, dec_r;

  // One guard bit above the level catches both overflow and underflow.
  assign lvl   = {1'b0, level_i};
  assign inc_a = (WIDTH+1)'(rate_inc(a_i, WIDTH));
  assign inc_d = (WIDTH+1)'(rate_inc(d_i, WIDTH));
  assign inc_r = (WIDTH+1)'(rate_inc(r_i, WIDTH));
  assign sl    = (WIDTH+1)'(sustain_level(s_i, WIDTH));
  assign sum_a = lvl + inc_a;
  assign dec_d = lvl - inc_d;
  assign dec_r = lvl - inc_r;

  always_comb begin
    next_state_o = state_i;
    next_level_o = level_i;
    if (!gate_i && (state_i == ATTACK || state_i == DECAY || state_i == SUSTAIN)) begin
      next_state_o = RELEASE;
    end else if (gate_i && pending_i) begin
      next_state_o = ATTACK;
      if (RESTART_ZERO != 0) next_level_o = '0;
    end else if (gate_i && (state_i == IDLE || state_i == RELEASE)) begin
      next_state_o = ATTACK;
    end else begin
      case (state_i)
        ATTACK: begin
          if (sum_a >= MAX) begin
            next_level_o = {WIDTH{1'b1}};
            next_state_o = DECAY;
          end else begin
            next_level_o = sum_a[WIDTH-1:0];
          end
        end
        DECAY: begin
          if (dec_d[WIDTH] || dec_d <= sl) begin
            next_level_o = sl[WIDTH-1:0];
            next_state_o = SUSTAIN;
          end else begin
            next_level_o = dec_d[WIDTH-1:0];
          end
        end
        SUSTAIN: next_level_o = sl[WIDTH-1:0];
        RELEASE: begin
          if (dec_r[WIDTH] || dec_r == '0) begin
            next_level_o = '0;
            next_state_o = IDLE;
          end else begin
            next_level_o = dec_r[WIDTH-1:0];
          end
        end
        default: begin
          next_level_o = '0;
          next_state_o = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/adsr_poly.sv
// Polyphonic ADSR: a low_clk rising edge starts a sweep that steps voice v at edge t0+1+v.
// Edges arriving mid-sweep are dropped and latch the sticky overrun flag.
module adsr_poly
  import adsr_pkg::*;
#(
  parameter int VOICES       = 4,
  parameter int WIDTH        = 16,
  parameter int RESTART_ZERO = 0
) (
  input logic   clk,
  input logic   rst,
  adsr_if.slave bus
);

  localparam int               IDX_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  state_t            state_q [VOICES];
  logic [WIDTH-1:0]  level_q [VOICES];
  logic [VOICES-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              low_clk_q;
  logic              tick;
  logic [VOICES-1:0] slot_mask;

  logic [3:0]        a_arr [VOICES];
  logic [3:0]        d_arr [VOICES];
  logic [3:0]        s_arr [VOICES];
  logic [3:0]        r_arr [VOICES];

  state_t            step_state_d;
  logic [WIDTH-1:0]  step_level_d;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    assign a_arr[v] = bus.a[4*v +: 4];
    assign d_arr[v] = bus.d[4*v +: 4];
    assign s_arr[v] = bus.s[4*v +: 4];
    assign r_arr[v] = bus.r[4*v +: 4];
    assign bus.signal_out[WIDTH*v +: WIDTH] = level_q[v];
    assign bus.active[v] = (state_q[v] != IDLE);
  end

  assign tick        = bus.low_clk & ~low_clk_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

  adsr_voice_step #(
    .WIDTH        (WIDTH),
    .RESTART_ZERO (RESTART_ZERO)
  ) u_step (
    .state_i      (state_q[idx_q]),
    .level_i      (level_q[idx_q]),
    .gate_i       (bus.gate[idx_q]),
    .pending_i    (pending_q[idx_q]),
    .a_i          (a_arr[idx_q]),
    .d_i          (d_arr[idx_q]),
    .s_i          (s_arr[idx_q]),
    .r_i          (r_arr[idx_q]),
    .next_state_o (step_state_d),
    .next_level_o (step_level_d)
  );

  always_comb begin
    busy_d    = busy_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    slot_mask = '0;
    if (busy_q) begin
      slot_mask[idx_q] = 1'b1;
      if (tick) overrun_d = 1'b1;
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (tick) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end
    // A retrig landing on its own slot survives to the next sweep.
    pending_d = bus.retrig | (pending_q & ~slot_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= IDLE;
        level_q[v] <= '0;
      end
      pending_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      low_clk_q <= 1'b0;
    end else begin
      low_clk_q <= bus.low_clk;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      if (busy_q) begin
        state_q[idx_q] <= step_state_d;
        level_q[idx_q] <= step_level_d;
      end
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: two instances (RESTART_ZERO 0 and 1) on shared stimulus,
// checked every cycle against an integer envelope model plus hand-computed levels.
`timescale 1ns/1ps
module tb_adsr_poly;
  localparam int V    = 4;
  localparam int W    = 16;
  localparam int MAXV = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             low_v;
  logic [3:0]       gate_v, retrig_v;
  logic [3:0][3:0]  a_v, d_v, s_v, r_v;

  adsr_if #(.VOICES(V), .WIDTH(W)) ifc0 ();
  adsr_if #(.VOICES(V), .WIDTH(W)) ifc1 ();

  assign ifc0.low_clk = low_v;  assign ifc1.low_clk = low_v;
  assign ifc0.gate    = gate_v; assign ifc1.gate    = gate_v;
  assign ifc0.retrig  = retrig_v; assign ifc1.retrig = retrig_v;
  assign ifc0.a = a_v; assign ifc1.a = a_v;
  assign ifc0.d = d_v; assign ifc1.d = d_v;
  assign ifc0.s = s_v; assign ifc1.s = s_v;
  assign ifc0.r = r_v; assign ifc1.r = r_v;

  adsr_poly #(.VOICES(V), .WIDTH(W), .RESTART_ZERO(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  adsr_poly #(.VOICES(V), .WIDTH(W), .RESTART_ZERO(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  int total = 0;
  int bad   = 0;

  // Model: k=0 restarts from current level, k=1 restarts from zero.
  int  m_lvl [2][V];
  int  m_st  [2][V];   // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  bit  m_pend[2][V];
  bit  m_ovr;
  int  cyc     = 0;
  int  t0      = -1;
  bit  prev_low = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_lvl(input int k, input int v);
    if (k == 0) return 32'(ifc0.signal_out[16*v +: 16]);
    return 32'(ifc1.signal_out[16*v +: 16]);
  endfunction
  function automatic logic [31:0] dut_act(input int k);
    return (k == 0) ? 32'(ifc0.active) : 32'(ifc1.active);
  endfunction
  function automatic logic [31:0] dut_busy(input int k);
    return (k == 0) ? 32'(ifc0.busy) : 32'(ifc1.busy);
  endfunction
  function automatic logic [31:0] dut_ovr(input int k);
    return (k == 0) ? 32'(ifc0.overrun) : 32'(ifc1.overrun);
  endfunction

  function automatic int inc(input int c);
    return 1 << (15 - c);
  endfunction

  task automatic eval(input int k, input int v);
    int lvl, st, sl;
    lvl = m_lvl[k][v];
    st  = m_st[k][v];
    sl  = int'(s_v[v]) * 4369;
    if (!gate_v[v] && (st == 1 || st == 2 || st == 3)) st = 4;
    else if (gate_v[v] && m_pend[k][v]) begin
      st = 1;
      if (k == 1) lvl = 0;
    end else if (gate_v[v] && (st == 0 || st == 4)) st = 1;
    else begin
      case (st)
        1: begin lvl += inc(int'(a_v[v])); if (lvl >= MAXV) begin lvl = MAXV; st = 2; end end
        2: begin lvl -= inc(int'(d_v[v])); if (lvl <= sl) begin lvl = sl; st = 3; end end
        3: lvl = sl;
        4: begin lvl -= inc(int'(r_v[v])); if (lvl <= 0) begin lvl = 0; st = 0; end end
        default: lvl = 0;
      endcase
    end
    m_lvl[k][v] = lvl;
    m_st[k][v]  = st;
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int v = 0; v < V; v++) begin
          m_lvl[k][v] = 0; m_st[k][v] = 0; m_pend[k][v] = 0;
        end
      m_ovr = 0; t0 = -1; prev_low = 0;
      return;
    end
    for (int v = 0; v < V; v++)
      if (t0 >= 0 && cyc == t0 + 1 + v)
        for (int k = 0; k < 2; k++) begin
          eval(k, v);
          m_pend[k][v] = 0;
        end
    for (int v = 0; v < V; v++)
      if (retrig_v[v]) begin m_pend[0][v] = 1; m_pend[1][v] = 1; end
    if (low_v && !prev_low) begin
      if (t0 >= 0 && cyc >= t0 + 1 && cyc <= t0 + V) m_ovr = 1;
      else t0 = cyc;
    end
    prev_low = low_v;
  endtask

  always @(posedge clk) begin
    logic [3:0] exp_act;
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_act = '0;
      for (int v = 0; v < V; v++) begin
        chk($sformatf("lvl k%0d v%0d", k, v), dut_lvl(k, v), m_lvl[k][v]);
        exp_act[v] = (m_st[k][v] != 0);
      end
      chk($sformatf("active k%0d", k), dut_act(k), 32'(exp_act));
      chk($sformatf("busy k%0d", k), dut_busy(k), 32'(t0 >= 0 && cyc >= t0 && cyc < t0 + V));
      chk($sformatf("overrun k%0d", k), dut_ovr(k), 32'(m_ovr));
    end
  end

  task automatic lit_lvl(input string nm, input int k, input int v, input int exp);
    chk({nm, " dut"}, dut_lvl(k, v), exp);
    chk({nm, " model"}, m_lvl[k][v], exp);
  endtask

  task automatic run_ticks(input int n, input int per, input bit rnd);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        low_v    = (c == 0);
        retrig_v = '0;
        if (rnd) begin
          int vv;
          vv = $urandom_range(0, 3);
          if ($urandom_range(0, 15) == 0) retrig_v = 4'($urandom);
          if ($urandom_range(0, 31) == 0) gate_v[vv] = ~gate_v[vv];
          if ($urandom_range(0, 47) == 0) begin
            a_v[vv] = 4'($urandom_range(0, 6));
            d_v[vv] = 4'($urandom_range(0, 7));
            s_v[vv] = 4'($urandom);
            r_v[vv] = 4'($urandom_range(0, 7));
          end
        end
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; low_v = 1'b0; retrig_v = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; low_v = 1'b0; gate_v = '0; retrig_v = '0;
    a_v = '0; d_v = '0; s_v = '0; r_v = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset lvl", dut_lvl(k, 0) | dut_lvl(k, 3), 0);
      chk("reset active", dut_act(k), 0);
      chk("reset busy", dut_busy(k), 0);
      chk("reset overrun", dut_ovr(k), 0);
    end
    rst = 1'b0;

    // Reset in the middle of a sweep.
    gate_v = 4'hF;
    run_ticks(2, 8, 0);
    lit_lvl("pre-rst attack", 0, 0, 32768);
    @(negedge clk); low_v = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst lvl", dut_lvl(k, 0) | dut_lvl(k, 1) | dut_lvl(k, 2), 0);
      chk("midrst active", dut_act(k), 0);
      chk("midrst busy", dut_busy(k), 0);
    end
    @(negedge clk); low_v = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_ticks(1, 8, 0);
    lit_lvl("post-rst from idle", 0, 0, 0);
    chk("post-rst active", dut_act(0), 32'hF);

    // Attack / decay / sustain on voice 0.
    do_reset();
    gate_v = 4'b0001; a_v[0] = 4'd0; d_v[0] = 4'd4; s_v[0] = 4'd7;
    run_ticks(1, 8, 0); lit_lvl("atk start", 0, 0, 0);
    run_ticks(1, 8, 0); lit_lvl("atk 1", 0, 0, 32768);
    run_ticks(1, 8, 0); lit_lvl("atk top", 1, 0, 65535);
    run_ticks(17, 8, 0); lit_lvl("decay 17", 0, 0, 30719);
    run_ticks(1, 8, 0); lit_lvl("decay 18", 0, 0, 16'h7777);
    run_ticks(2, 8, 0); lit_lvl("sustain hold", 1, 0, 16'h7777);

    // Release.
    r_v[0] = 4'd3; gate_v[0] = 1'b0;
    run_ticks(1, 8, 0); lit_lvl("rel hold", 0, 0, 16'h7777);
    run_ticks(7, 8, 0); lit_lvl("rel 7", 0, 0, 1911);
    chk("rel active", dut_act(0), 1);
    run_ticks(1, 8, 0); lit_lvl("rel end", 0, 0, 0);
    chk("rel idle", dut_act(0), 0);

    // Retrig from sustain, then gate-on during release.
    a_v[0] = 4'd0; d_v[0] = 4'd0; s_v[0] = 4'd8; gate_v[0] = 1'b1;
    run_ticks(4, 8, 0);
    lit_lvl("sus 8 k0", 0, 0, 34952); lit_lvl("sus 8 k1", 1, 0, 34952);
    retrig_v[0] = 1'b1;
    @(negedge clk); retrig_v = '0;
    run_ticks(1, 8, 0);
    lit_lvl("retrig keep", 0, 0, 34952); lit_lvl("retrig zero", 1, 0, 0);
    run_ticks(1, 8, 0);
    lit_lvl("retrig atk k0", 0, 0, 65535); lit_lvl("retrig atk k1", 1, 0, 32768);
    run_ticks(2, 8, 0);
    lit_lvl("resettle k0", 0, 0, 34952); lit_lvl("resettle k1", 1, 0, 34952);
    r_v[0] = 4'd1; gate_v[0] = 1'b0;
    run_ticks(2, 8, 0); lit_lvl("rel L", 0, 0, 18568);
    a_v[0] = 4'd1; gate_v[0] = 1'b1;
    run_ticks(1, 8, 0); lit_lvl("reatk no jump", 0, 0, 18568);
    run_ticks(1, 8, 0); lit_lvl("reatk step", 0, 0, 34952);

    // Randomized traffic with varying sample periods.
    for (int v = 0; v < V; v++) begin
      a_v[v] = 4'($urandom_range(0, 6)); d_v[v] = 4'($urandom_range(0, 7));
      s_v[v] = 4'($urandom);             r_v[v] = 4'($urandom_range(0, 7));
    end
    for (int i = 0; i < 300; i++) run_ticks(1, $urandom_range(5, 12), 1);

    // Alternate gates, busy length, then overrun.
    do_reset();
    gate_v = 4'b0101;
    for (int v = 0; v < V; v++) begin a_v[v] = 4'd2; d_v[v] = 4'd3; s_v[v] = 4'd9; r_v[v] = 4'd2; end
    run_ticks(2, 8, 0);
    @(negedge clk); low_v = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk); low_v = 1'b0;
      if (ifc0.busy === 1'b1) cnt++;
    end
    chk("busy cycles", cnt, 4);
    lit_lvl("alt v0", 0, 0, 16384); lit_lvl("alt v1", 0, 1, 0); lit_lvl("alt v3", 1, 3, 0);
    chk("alt active", dut_act(1), 4'b0101);
    chk("no overrun yet", dut_ovr(0), 0);
    repeat (6) begin
      @(negedge clk); low_v = 1'b1;
      @(negedge clk); low_v = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("overrun k0", dut_ovr(0), 1); chk("overrun k1", dut_ovr(1), 1);
    run_ticks(2, 8, 0);
    chk("overrun sticky", dut_ovr(0), 1);
    do_reset();
    @(negedge clk);
    chk("overrun cleared", dut_ovr(0), 0);
    run_ticks(2, 8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
